// File: rtl/serial_word_loader_if.sv
// Serial frame input and parallel word output bundle for serial_word_loader.
// master: stream source / register side; slave: the loader itself.
interface serial_word_loader_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             load_en;
    logic             frame_err;
    logic             busy;

    modport master (
        output sin,
        output sin_valid,
        input  dout,
        input  load_en,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  sin,
        input  sin_valid,
        output dout,
        output load_en,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_word_loader.sv
// Deframes start/WIDTH data (LSB-first)/stop serial frames into a word.
// Ports: clk, rst (async high), bus (slave): sin/sin_valid in; dout/load_en/frame_err/busy out.
module serial_word_loader #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_word_loader_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             load_q;
    logic             load_nx;
    logic             err_q;
    logic             err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            dout_q <= '0;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            cnt    <= cnt_nx;
            dout_q <= dout_nx;
            load_q <= load_nx;
            err_q  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        dout_nx  = dout_q;
        load_nx  = 1'b0;
        err_nx   = 1'b0;
        if (bus.sin_valid) begin
            unique case (state)
                IDLE: begin
                    if (!bus.sin) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    // New bit enters at the MSB so the first bit ends at bit 0.
                    shreg_nx = {bus.sin, shreg[WIDTH-1:1]};
                    cnt_nx   = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nx = STOP;
                    end
                end
                STOP: begin
                    // A 0 here is a bad stop bit, never a new start bit.
                    if (bus.sin) begin
                        dout_nx = shreg;
                        load_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.load_en   = load_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_serial_word_loader.sv
// Directed self-checking bench for serial_word_loader.
// Drives framed serial bits and checks dout, load_en, frame_err and busy.
module tb_serial_word_loader;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_word_loader_if #(.WIDTH(4)) bus ();

    serial_word_loader #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic b, input logic v);
        bus.sin       = b;
        bus.sin_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dout: got %b expected 0000", bus.dout);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.load_en !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got load=%b err=%b expected 0 0",
                     bus.load_en, bus.frame_err);
        end
        rst = 1'b0;
        drive(1'b1, 1'b0);
    endtask

    task automatic test_single();
        logic fb[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(fb[i], 1'b1);
            checks++;
            if (bus.busy !== (i < 5)) begin
                errors++;
                $display("FAIL single_busy[%0d]: got %b expected %b",
                         i, bus.busy, (i < 5));
            end
            checks++;
            if (bus.load_en !== (i == 5) || bus.frame_err !== 1'b0) begin
                errors++;
                $display("FAIL single_pulse[%0d]: got load=%b err=%b expected %b 0",
                         i, bus.load_en, bus.frame_err, (i == 5));
            end
        end
        checks++;
        if (bus.dout !== 4'b0111) begin
            errors++;
            $display("FAIL single_dout: got %b expected 0111", bus.dout);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (bus.load_en !== 1'b0 || bus.dout !== 4'b0111) begin
            errors++;
            $display("FAIL single_after: got load=%b dout=%b expected 0 0111",
                     bus.load_en, bus.dout);
        end
    endtask

    task automatic test_gaps();
        logic fb[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   loads;
        int   errs;
        logic bsy;
        loads = 0;
        errs  = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(fb[i], 1'b1);
            bsy = bus.busy;
            if (bus.load_en) loads++;
            if (bus.frame_err) errs++;
            for (int g = 0; g < 3; g++) begin
                drive(~fb[i], 1'b0);
                if (bus.load_en) loads++;
                if (bus.frame_err) errs++;
                checks++;
                if (bus.busy !== bsy) begin
                    errors++;
                    $display("FAIL gap_busy[%0d.%0d]: got %b expected %b",
                             i, g, bus.busy, bsy);
                end
            end
        end
        checks++;
        if (loads != 1 || errs != 0) begin
            errors++;
            $display("FAIL gap_pulses: got loads=%0d errs=%0d expected 1 0",
                     loads, errs);
        end
        checks++;
        if (bus.dout !== 4'b0111 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_dout: got dout=%b busy=%b expected 0111 0",
                     bus.dout, bus.busy);
        end
    endtask

    task automatic test_frame_err();
        logic fb[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int   loads;
        loads = 0;
        for (int i = 0; i < 6; i++) begin
            drive(fb[i], 1'b1);
            if (bus.load_en) loads++;
            checks++;
            if (bus.frame_err !== (i == 5)) begin
                errors++;
                $display("FAIL ferr_pulse[%0d]: got %b expected %b",
                         i, bus.frame_err, (i == 5));
            end
        end
        checks++;
        if (loads != 0 || bus.dout !== 4'b0111) begin
            errors++;
            $display("FAIL ferr_hold: got loads=%0d dout=%b expected 0 0111",
                     loads, bus.dout);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_busy: got %b expected 0", bus.busy);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_after: got err=%b busy=%b expected 0 0",
                     bus.frame_err, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic fb[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int   loads;
        loads = 0;
        for (int i = 0; i < 12; i++) begin
            drive(fb[i], 1'b1);
            if (bus.load_en) loads++;
            if (i == 5) begin
                checks++;
                if (bus.load_en !== 1'b1 || bus.dout !== 4'b0111) begin
                    errors++;
                    $display("FAIL b2b_first: got load=%b dout=%b expected 1 0111",
                             bus.load_en, bus.dout);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.load_en !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_start: got busy=%b load=%b expected 1 0",
                             bus.busy, bus.load_en);
                end
            end
            if (i == 11) begin
                checks++;
                if (bus.load_en !== 1'b1 || bus.dout !== 4'b1010) begin
                    errors++;
                    $display("FAIL b2b_second: got load=%b dout=%b expected 1 1010",
                             bus.load_en, bus.dout);
                end
            end
        end
        checks++;
        if (loads != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", loads);
        end
    endtask

    task automatic test_reset_mid();
        logic fb[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int   loads;
        int   errs;
        loads = 0;
        errs  = 0;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        checks++;
        if (bus.dout !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state: got dout=%b busy=%b expected 0000 0",
                     bus.dout, bus.busy);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (bus.load_en !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pulses: got load=%b err=%b expected 0 0",
                     bus.load_en, bus.frame_err);
        end
        for (int i = 0; i < 6; i++) begin
            drive(fb[i], 1'b1);
            if (bus.load_en) loads++;
            if (bus.frame_err) errs++;
        end
        checks++;
        if (loads != 1 || errs != 0 || bus.dout !== 4'b1010) begin
            errors++;
            $display("FAIL rmid_reload: got loads=%0d errs=%0d dout=%b expected 1 0 1010",
                     loads, errs, bus.dout);
        end
    endtask

    task automatic test_idle_ones();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (bus.busy !== 1'b0 || bus.load_en !== 1'b0 ||
                bus.frame_err !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: got busy=%b load=%b err=%b expected 0 0 0",
                         i, bus.busy, bus.load_en, bus.frame_err);
            end
        end
        checks++;
        if (bus.dout !== 4'b1010) begin
            errors++;
            $display("FAIL idle_dout: got %b expected 1010", bus.dout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sin = 1'b1;
        bus.sin_valid = 1'b0;
        test_reset();
        test_single();
        test_gaps();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_idle_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
